// File: rtl/pma_rule_scanner.sv
// pma_rule_scanner
//   Runtime-programmable physical-memory-attribute table with a sequential
//   lookup engine. Rules are written through the cfg port; a lookup walks the
//   table one slot per cycle and returns the OR of every matching slot's
//   attributes, plus the lowest-numbered matching slot.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   flush_i                 abort any lookup in flight, drop its response
//   cfg_valid_i/ready_o     rule write handshake (idx, base, len, attr)
//   req_valid_i/ready_o     lookup request handshake (addr)
//   resp_valid_o/ready_i    lookup result handshake (hit, idx, attr)
//   attr encoding           {cached, execute, nonidempotent}
module pma_rule_scanner #(
  parameter int unsigned NrRules   = 16,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned IdxWidth  = (NrRules > 1) ? $clog2(NrRules) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 cfg_valid_i,
  output logic                 cfg_ready_o,
  input  logic [IdxWidth-1:0]  cfg_idx_i,
  input  logic [AddrWidth-1:0] cfg_base_i,
  input  logic [AddrWidth-1:0] cfg_len_i,
  input  logic [2:0]           cfg_attr_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic                 resp_hit_o,
  output logic [IdxWidth-1:0]  resp_idx_o,
  output logic [2:0]           resp_attr_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NrRules - 1);

  // Region match. The end bound is formed one bit wider than the address so a
  // region that ends exactly at the top of the address space does not wrap.
  // A zero-length slot is disabled.
  function automatic logic rule_match(input logic [AddrWidth-1:0] addr,
                                      input logic [AddrWidth-1:0] base,
                                      input logic [AddrWidth-1:0] len);
    logic [AddrWidth:0] limit;
    limit = {1'b0, base} + {1'b0, len};
    return (len != '0) && (addr >= base) && ({1'b0, addr} < limit);
  endfunction

  logic [1:0]           state_q, state_d;
  logic [IdxWidth-1:0]  cnt_q, cnt_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic                 hit_q, hit_d;
  logic [IdxWidth-1:0]  idx_q, idx_d;
  logic [2:0]           acc_q, acc_d;

  logic [AddrWidth-1:0] base_q [NrRules];
  logic [AddrWidth-1:0] base_d [NrRules];
  logic [AddrWidth-1:0] len_q  [NrRules];
  logic [AddrWidth-1:0] len_d  [NrRules];
  logic [2:0]           attr_q [NrRules];
  logic [2:0]           attr_d [NrRules];

  logic        is_idle;
  logic        cfg_fire;
  logic        req_fire;
  logic        cfg_idx_ok;
  logic        slot_match;
  logic [31:0] cfg_idx_ext;

  // Readies are also held low while reset is asserted so that every output
  // reads 0 during reset; they return to 1 once reset is released in IDLE.
  assign is_idle     = (state_q == ST_IDLE);
  assign cfg_ready_o = is_idle && !flush_i && !rst_i;
  assign req_ready_o = is_idle && !flush_i && !rst_i && !cfg_valid_i;
  assign cfg_fire    = cfg_valid_i && cfg_ready_o;
  assign req_fire    = req_valid_i && req_ready_o;

  // Out-of-range slot numbers complete the handshake but write nothing.
  assign cfg_idx_ext = 32'(cfg_idx_i);
  assign cfg_idx_ok  = (cfg_idx_ext < NrRules);

  assign slot_match  = rule_match(addr_q, base_q[cnt_q], len_q[cnt_q]);

  assign resp_valid_o = (state_q == ST_RESP);
  assign resp_hit_o   = hit_q;
  assign resp_idx_o   = idx_q;
  assign resp_attr_o  = acc_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    hit_d   = hit_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    base_d  = base_q;
    len_d   = len_q;
    attr_d  = attr_q;

    // Writes are only accepted in IDLE, so a walk never sees the table move.
    if (cfg_fire && cfg_idx_ok) begin
      base_d[cfg_idx_i] = cfg_base_i;
      len_d[cfg_idx_i]  = cfg_len_i;
      attr_d[cfg_idx_i] = cfg_attr_i;
    end

    if (flush_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_fire) begin
            addr_d  = req_addr_i;
            hit_d   = 1'b0;
            idx_d   = '0;
            acc_d   = 3'b000;
            cnt_d   = '0;
            state_d = ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (slot_match) begin
            acc_d = acc_q | attr_q[cnt_q];
            // Slots are visited in ascending order, so the first hit is the
            // lowest-numbered one.
            if (!hit_q) begin
              hit_d = 1'b1;
              idx_d = cnt_q;
            end
          end
          if (cnt_q == LastIdx) begin
            state_d = ST_RESP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_RESP: begin
          if (resp_ready_i) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      hit_q   <= 1'b0;
      idx_q   <= '0;
      acc_q   <= 3'b000;
      for (int i = 0; i < NrRules; i++) begin
        base_q[i] <= '0;
        len_q[i]  <= '0;
        attr_q[i] <= 3'b000;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      hit_q   <= hit_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      base_q  <= base_d;
      len_q   <= len_d;
      attr_q  <= attr_d;
    end
  end

endmodule

// File: tb/tb_pma_rule_scanner.sv
// tb_pma_rule_scanner
//   Directed bench for pma_rule_scanner (NrRules = 16, AddrWidth = 64).
//   Inputs change at the negative edge or 1 time unit after a positive edge;
//   outputs are sampled away from the positive edge.
module tb_pma_rule_scanner;

  localparam int unsigned NR = 16;
  localparam int unsigned AW = 64;
  localparam int unsigned IW = 4;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [IW-1:0] cfg_idx;
  logic [AW-1:0] cfg_base;
  logic [AW-1:0] cfg_len;
  logic [2:0]    cfg_attr;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          resp_valid;
  logic          resp_ready;
  logic          resp_hit;
  logic [IW-1:0] resp_idx;
  logic [2:0]    resp_attr;

  int vectors;
  int miscompares;

  pma_rule_scanner #(
    .NrRules  (NR),
    .AddrWidth(AW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .cfg_valid_i (cfg_valid),
    .cfg_ready_o (cfg_ready),
    .cfg_idx_i   (cfg_idx),
    .cfg_base_i  (cfg_base),
    .cfg_len_i   (cfg_len),
    .cfg_attr_i  (cfg_attr),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .resp_valid_o(resp_valid),
    .resp_ready_i(resp_ready),
    .resp_hit_o  (resp_hit),
    .resp_idx_o  (resp_idx),
    .resp_attr_o (resp_attr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negative edge; returns 1 unit after the accepting edge.
  task automatic cfg_write(input logic [IW-1:0] idx, input logic [AW-1:0] base,
                           input logic [AW-1:0] len, input logic [2:0] attr);
    cfg_idx   = idx;
    cfg_base  = base;
    cfg_len   = len;
    cfg_attr  = attr;
    cfg_valid = 1'b1;
    #1;
    check("cfg_ready_idle", cfg_ready, 1'b1);
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  // Returns 1 unit after the edge that accepted the request.
  task automatic send_req(input logic [AW-1:0] addr);
    int guard;
    guard     = 0;
    req_addr  = addr;
    req_valid = 1'b1;
    #1;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    check("req_accept", req_ready, 1'b1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Latency counts edges from the accepting edge (counted as 1) until
  // resp_valid is seen.
  task automatic wait_resp(output int lat);
    lat = 1;
    while (!resp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check("resp_valid_drops", resp_valid, 1'b0);
    check("ready_after_resp", req_ready, 1'b1);
    @(negedge clk);
  endtask

  task automatic lookup(input string tag, input logic [AW-1:0] addr,
                        input logic e_hit, input logic [IW-1:0] e_idx, input logic [2:0] e_attr);
    int lat;
    send_req(addr);
    wait_resp(lat);
    check({tag, "_latency"}, 64'(lat), 64'd17);
    check({tag, "_hit"}, resp_hit, e_hit);
    check({tag, "_idx"}, resp_idx, e_idx);
    check({tag, "_attr"}, resp_attr, e_attr);
    finish_resp();
  endtask

  initial begin
    int  lat;
    logic saw_valid;
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    flush       = 1'b0;
    cfg_valid   = 1'b0;
    cfg_idx     = '0;
    cfg_base    = '0;
    cfg_len     = '0;
    cfg_attr    = 3'b000;
    req_valid   = 1'b0;
    req_addr    = '0;
    resp_ready  = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_cfg_ready", cfg_ready, 1'b1);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_hit", resp_hit, 1'b0);
    check("rst_idx", resp_idx, 4'd0);
    check("rst_attr", resp_attr, 3'b000);

    // Empty table
    lookup("empty", 64'h0000_0000_8000_0000, 1'b0, 4'd0, 3'b000);

    // Overlapping rules
    cfg_write(4'd3, 64'h0000_0000_8000_0000, 64'h0000_0000_1000_0000, 3'b110);
    @(negedge clk);
    cfg_write(4'd7, 64'h0000_0000_8800_0000, 64'h0000_0000_0100_0000, 3'b001);
    @(negedge clk);
    lookup("overlap", 64'h0000_0000_8800_0010, 1'b1, 4'd3, 3'b111);
    lookup("slot3_end", 64'h0000_0000_8FFF_FFFF, 1'b1, 4'd3, 3'b110);
    lookup("past_end", 64'h0000_0000_9000_0000, 1'b0, 4'd0, 3'b000);

    // Region ending at the top of the address space
    cfg_write(4'd0, 64'hFFFF_FFFF_FFFF_F000, 64'h0000_0000_0000_1000, 3'b010);
    @(negedge clk);
    lookup("top", 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd0, 3'b010);

    // Simultaneous cfg and req: cfg first, request one cycle later and it
    // already sees the new slot.
    cfg_idx   = 4'd5;
    cfg_base  = 64'h0000_0000_0000_1000;
    cfg_len   = 64'h0000_0000_0000_0100;
    cfg_attr  = 3'b100;
    cfg_valid = 1'b1;
    req_addr  = 64'h0000_0000_0000_1080;
    req_valid = 1'b1;
    #1;
    check("prio_cfg_ready", cfg_ready, 1'b1);
    check("prio_req_blocked", req_ready, 1'b0);
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    #1;
    check("prio_req_ready_next", req_ready, 1'b1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    wait_resp(lat);
    check("prio_latency", 64'(lat), 64'd17);

    // Backpressure: hold the response for 5 cycles
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", resp_valid, 1'b1);
      check("bp_hit", resp_hit, 1'b1);
      check("bp_idx", resp_idx, 4'd5);
      check("bp_attr", resp_attr, 3'b100);
      check("bp_cfg_ready", cfg_ready, 1'b0);
    end
    finish_resp();

    // Flush blocks handshakes in IDLE
    flush = 1'b1;
    #1;
    check("flush_idle_cfg_ready", cfg_ready, 1'b0);
    check("flush_idle_req_ready", req_ready, 1'b0);
    flush = 1'b0;
    @(negedge clk);

    // Flush mid-scan: asserted in the fifth cycle after the accepting edge
    send_req(64'h0000_0000_8800_0010);
    repeat (4) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    #1;
    check("flush_idle_after", cfg_ready, 1'b1);
    saw_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resp_valid) saw_valid = 1'b1;
    end
    check("flush_no_resp", saw_valid, 1'b0);
    lookup("after_flush", 64'h0000_0000_8800_0010, 1'b1, 4'd3, 3'b111);

    // Reset mid-scan
    send_req(64'h0000_0000_8800_0010);
    repeat (7) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_cfg_ready", cfg_ready, 1'b0);
    check("midrst_req_ready", req_ready, 1'b0);
    check("midrst_resp_valid", resp_valid, 1'b0);
    check("midrst_hit", resp_hit, 1'b0);
    check("midrst_idx", resp_idx, 4'd0);
    check("midrst_attr", resp_attr, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("postrst_req_ready", req_ready, 1'b1);
    lookup("table_cleared", 64'h0000_0000_8800_0010, 1'b0, 4'd0, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pma_rule_scanner.md
# pma_rule_scanner

Runtime-programmable physical-memory-attribute (PMA) table with a sequential lookup engine. A configuration port writes each rule; a request port submits an address. The engine walks the table one rule per cycle and returns the OR-ed attributes of every matching rule. It serves uncore masters (DMA, debug, accelerators) that need PMA answers without the area of a fully parallel comparator bank.

## Interface
Parameters:
- NrRules, 16: number of rule slots; legal range 1..16.
- AddrWidth, 64: address, base and length width.
- IdxWidth, (NrRules > 1) ? $clog2(NrRules) : 1: rule index width (derived).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- flush_i  in  1  aborts any lookup in flight; drops its response.
- cfg_valid_i  in  1  rule write request.
- cfg_ready_o  out  1  rule write accepted.
- cfg_idx_i  in  IdxWidth  slot written.
- cfg_base_i  in  AddrWidth  region base.
- cfg_len_i  in  AddrWidth  region length in bytes; 0 disables the slot.
- cfg_attr_i  in  3  {cached, execute, nonidempotent}.
- req_valid_i  in  1  lookup request.
- req_ready_o  out  1  lookup accepted.
- req_addr_i  in  AddrWidth  address to classify.
- resp_valid_o  out  1  result available.
- resp_ready_i  in  1  result consumed.
- resp_hit_o  out  1  at least one rule matched.
- resp_idx_o  out  IdxWidth  lowest-numbered matching slot; 0 when there is no hit.
- resp_attr_o  out  3  OR of the attributes of all matching slots.

## Operation
- Table storage: NrRules × {base, len, attr}. Reset clears every field to 0, so every slot is disabled.
- Match rule: addr >= base && {1'b0, addr} < ({1'b0, base} + {1'b0, len}). The sum is computed at AddrWidth+1 bits, so a region ending at 2^AddrWidth does not overflow. A slot with len = 0 never matches.
- FSM has three states:
  - IDLE: on a req handshake, latch the address, clear hit/idx/attr accumulators, set cnt = 0, go to SCAN.
  - SCAN: evaluate slot cnt. On a match, OR its attr into the accumulator. On the first match, set hit and record idx = cnt. When cnt == NrRules-1, go to RESP; otherwise cnt++.
  - RESP: resp_valid_o = 1. On resp_ready_i, go to IDLE.
- Outputs in RESP come straight from the accumulator registers and stay stable until the handshake.
- cfg_ready_o = (state == IDLE). A write lands in the table at the clock edge of the handshake, so a scan never sees the table change mid-walk.
- req_ready_o = (state == IDLE) && !cfg_valid_i. Configuration has priority over a simultaneous request; the request waits one cycle.
- flush_i, in any state: next state is IDLE and no response is produced. The table is untouched. In IDLE, flush_i also blocks the handshake that cycle (req_ready_o and cfg_ready_o are forced to 0).
- cfg_idx_i >= NrRules: the handshake completes but no slot is written.
- rst_i asserted mid-scan or mid-response: immediately go to IDLE, clear the table, and drive every output to 0.

## Timing
- Reset values: cfg_ready_o = 1 and req_ready_o = 1 (given cfg_valid_i and flush_i low). resp_valid_o, resp_hit_o, resp_idx_o and resp_attr_o are all 0.
- Request handshake at edge T: slot k is evaluated in cycle T+1+k, and resp_valid_o rises in cycle T+1+NrRules.
  - NrRules = 16 gives 17 cycles from handshake to response.
- Response handshake at edge R: the block is in IDLE at R+1 and can accept the next request in that cycle. Peak throughput is one lookup per NrRules+2 cycles.
- A configuration write becomes visible to any request accepted at or after the following edge.
- There are no combinational paths from req_* or resp_ready_i to any output. The ready outputs depend only on state, flush_i and cfg_valid_i.

## Test plan
- Reset, then request 0x8000_0000 with an empty table -> after 17 cycles: resp_hit_o = 0, resp_idx_o = 0, resp_attr_o = 3'b000.
- Overlapping rules:
  - Program slot 3 = {base 0x8000_0000, len 0x1000_0000, attr 3'b110} and slot 7 = {base 0x8800_0000, len 0x100_0000, attr 3'b001}.
  - Request 0x8800_0010 -> hit = 1, idx = 3, attr = 3'b111.
  - Request 0x8FFF_FFFF -> idx = 3, attr = 3'b110.
  - Request 0x9000_0000 -> hit = 0.
- Top-of-space region: slot 0 = {base 0xFFFF_FFFF_FFFF_F000, len 0x1000, attr 3'b010}. Request 0xFFFF_FFFF_FFFF_FFFF -> hit = 1, attr = 3'b010 (no overflow).
- Priority and backpressure:
  - Assert cfg_valid_i and req_valid_i in the same IDLE cycle -> cfg accepted first, req_ready_o = 0 that cycle, request accepted on the next cycle.
  - Hold resp_ready_i low for 5 cycles -> outputs stable, cfg_ready_o = 0 throughout.
- Flush: assert flush_i in cycle T+5 of a scan -> no resp_valid_o, IDLE at T+6. The next request completes normally with table contents preserved.
- Reset mid-scan: assert rst_i in cycle T+8 -> all outputs 0 immediately. A later request for a previously matching address returns hit = 0.
